// File: rtl/tri_shade_pkg.sv
// Shared types and constants for the triangle shading sequencer and its scaler.
package tri_shade_pkg;

    localparam int unsigned NWORDS = 10;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned TMR_W  = 8;

    localparam logic [WCNT_W-1:0] IDX_AX  = 4'd0;
    localparam logic [WCNT_W-1:0] IDX_AY  = 4'd1;
    localparam logic [WCNT_W-1:0] IDX_AZ  = 4'd2;
    localparam logic [WCNT_W-1:0] IDX_BX  = 4'd3;
    localparam logic [WCNT_W-1:0] IDX_BY  = 4'd4;
    localparam logic [WCNT_W-1:0] IDX_BZ  = 4'd5;
    localparam logic [WCNT_W-1:0] IDX_CX  = 4'd6;
    localparam logic [WCNT_W-1:0] IDX_CY  = 4'd7;
    localparam logic [WCNT_W-1:0] IDX_CZ  = 4'd8;
    localparam logic [WCNT_W-1:0] IDX_COL = WCNT_W'(NWORDS - 1);

    // RGB565 field positions
    localparam int unsigned R_LSB = 11;
    localparam int unsigned R_W   = 5;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_LSB = 0;
    localparam int unsigned B_W   = 5;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/shade_scale.sv
// Combinational RGB565 x shade scaler: each channel is (c * s) >> SHADE_W, truncated.
module shade_scale
    import tri_shade_pkg::*;
#(
    parameter int unsigned SHADE_W = 6
) (
    input  logic [15:0]        color,
    input  logic [SHADE_W-1:0] shade,
    output logic [15:0]        scaled_c
);

    localparam int unsigned RP_W = R_W + SHADE_W;
    localparam int unsigned GP_W = G_W + SHADE_W;
    localparam int unsigned BP_W = B_W + SHADE_W;

    logic [RP_W-1:0] rp;
    logic [GP_W-1:0] gp;
    logic [BP_W-1:0] bp;

    assign rp = RP_W'(color[R_LSB +: R_W]) * RP_W'(shade);
    assign gp = GP_W'(color[G_LSB +: G_W]) * GP_W'(shade);
    assign bp = BP_W'(color[B_LSB +: B_W]) * BP_W'(shade);

    always_comb begin
        scaled_c                = '0;
        scaled_c[R_LSB +: R_W]  = R_W'(rp >> SHADE_W);
        scaled_c[G_LSB +: G_W]  = G_W'(gp >> SHADE_W);
        scaled_c[B_LSB +: B_W]  = B_W'(bp >> SHADE_W);
    end

endmodule

// File: rtl/tri_shade_seq.sv
// Collects one triangle from a word stream, drives the lighting block, waits
// the settle window, then emits the base colour scaled by the returned shade.
module tri_shade_seq
    import tri_shade_pkg::*;
#(
    parameter int unsigned WII     = 8,
    parameter int unsigned WIF     = 8,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned SHADE_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [WII+WIF-1:0]   ax,
    output logic [WII+WIF-1:0]   ay,
    output logic [WII+WIF-1:0]   az,
    output logic [WII+WIF-1:0]   bx,
    output logic [WII+WIF-1:0]   by,
    output logic [WII+WIF-1:0]   bz,
    output logic [WII+WIF-1:0]   cx,
    output logic [WII+WIF-1:0]   cy,
    output logic [WII+WIF-1:0]   cz,
    input  logic [SHADE_W-1:0]   shade_in,
    output logic [15:0]          m_color,
    output logic [SHADE_W-1:0]   m_shade,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err,
    output logic [15:0]          tri_cnt
);

    localparam int unsigned CW = WII + WIF;

    state_e             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               s_ready_q, m_valid_q;
    logic               word_we, err_set, capture, cnt_inc;
    logic [15:0]        col;
    logic [15:0]        scaled_c;

    // s_ready is forced low combinationally while rst is held
    assign s_ready = s_ready_q & ~rst;
    assign m_valid = m_valid_q;

    shade_scale #(.SHADE_W(SHADE_W)) u_scale (
        .color    (col),
        .shade    (shade_in),
        .scaled_c (scaled_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            wcnt      <= '0;
            timer     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            timer     <= timer_nxt;
            s_ready_q <= (state_nxt == LOAD);
            m_valid_q <= (state_nxt == EMIT);
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        timer_nxt = timer;
        word_we   = 1'b0;
        err_set   = 1'b0;
        capture   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    // s_last must mark exactly the colour word
                    if (s_last != (wcnt == IDX_COL)) begin
                        err_set  = 1'b1;
                        wcnt_nxt = '0;
                    end else if (wcnt == IDX_COL) begin
                        word_we   = 1'b1;
                        wcnt_nxt  = '0;
                        timer_nxt = TMR_W'(SETTLE - 1);
                        state_nxt = WAIT;
                    end else begin
                        word_we  = 1'b1;
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (timer != '0) begin
                    timer_nxt = timer - TMR_W'(1);
                end else begin
                    capture   = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath registers: vertex/colour capture, shaded result, status
    always_ff @(posedge clk) begin
        if (rst) begin
            ax      <= '0;
            ay      <= '0;
            az      <= '0;
            bx      <= '0;
            by      <= '0;
            bz      <= '0;
            cx      <= '0;
            cy      <= '0;
            cz      <= '0;
            col     <= '0;
            m_color <= '0;
            m_shade <= '0;
            err     <= 1'b0;
            tri_cnt <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            if (word_we) begin
                case (wcnt)
                    IDX_AX:  ax  <= CW'(s_data);
                    IDX_AY:  ay  <= CW'(s_data);
                    IDX_AZ:  az  <= CW'(s_data);
                    IDX_BX:  bx  <= CW'(s_data);
                    IDX_BY:  by  <= CW'(s_data);
                    IDX_BZ:  bz  <= CW'(s_data);
                    IDX_CX:  cx  <= CW'(s_data);
                    IDX_CY:  cy  <= CW'(s_data);
                    IDX_CZ:  cz  <= CW'(s_data);
                    IDX_COL: col <= s_data;
                    default: ;
                endcase
            end
            if (capture) begin
                m_shade <= shade_in;
                m_color <= scaled_c;
            end
            if (cnt_inc) begin
                tri_cnt <= tri_cnt + 16'd1;
            end
        end
    end

endmodule
